// File: rtl/mycpu_pkg.sv
// Shared constants and types for the execute stage: ALU/MD/HILO one-hot
// bit positions, the divider state encoding and the divide step count.
package mycpu_pkg;

  localparam int DIV_STEPS = 32;

  // one-hot ALU operation bit positions
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  // one-hot multiply/divide operation bit positions
  localparam int MD_MULT  = 0;
  localparam int MD_MULTU = 1;
  localparam int MD_DIV   = 2;
  localparam int MD_DIVU  = 3;

  // one-hot HI/LO move operation bit positions
  localparam int HILO_MFHI = 0;
  localparam int HILO_MFLO = 1;
  localparam int HILO_MTHI = 2;
  localparam int HILO_MTLO = 3;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/exe_stage_if.sv
// Decode->execute and execute->memory handshake/bus signals.
// Handshake: a stage transfers data on a clock edge exactly when its
// valid and the receiver's allowin are both high; valid never depends
// combinationally on the receiver's allowin.
interface exe_stage_if;
  logic        ds_to_es_valid;
  logic        es_allowin;
  logic [11:0] ds_alu_op;
  logic [31:0] ds_src1;
  logic [31:0] ds_src2;
  logic [3:0]  ds_md_op;
  logic [3:0]  ds_hilo_op;
  logic        ds_ov_en;
  logic [4:0]  ds_dest;
  logic [31:0] ds_pc;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [31:0] es_result;
  logic [4:0]  es_dest;
  logic [31:0] es_pc;
  logic        es_ex;

  // surrounding pipeline (decode + memory) view
  modport master (
    output ds_to_es_valid, ds_alu_op, ds_src1, ds_src2, ds_md_op,
           ds_hilo_op, ds_ov_en, ds_dest, ds_pc, ms_allowin,
    input  es_allowin, es_to_ms_valid, es_result, es_dest, es_pc, es_ex
  );

  // execute stage view
  modport slave (
    input  ds_to_es_valid, ds_alu_op, ds_src1, ds_src2, ds_md_op,
           ds_hilo_op, ds_ov_en, ds_dest, ds_pc, ms_allowin,
    output es_allowin, es_to_ms_valid, es_result, es_dest, es_pc, es_ex
  );
endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU with one-hot op select and add/sub overflow flag.
module alu
  import mycpu_pkg::*;
(
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result,
  output logic        overflow
);

  logic        use_sub;
  logic [31:0] b_in;
  logic [32:0] sum;
  logic        slt_res;
  logic        sltu_res;
  logic [31:0] sra_res;

  // sub/slt/sltu share the adder as a + ~b + 1
  assign use_sub  = alu_op[ALU_SUB] | alu_op[ALU_SLT] | alu_op[ALU_SLTU];
  assign b_in     = use_sub ? ~alu_src2 : alu_src2;
  assign sum      = {1'b0, alu_src1} + {1'b0, b_in} + {32'b0, use_sub};
  assign slt_res  = (alu_src1[31] & ~alu_src2[31]) |
                    (~(alu_src1[31] ^ alu_src2[31]) & sum[31]);
  assign sltu_res = ~sum[32];
  assign sra_res  = 32'($signed(alu_src2) >>> alu_src1[4:0]);

  // same-sign inputs to the adder producing an opposite-sign sum
  assign overflow = (alu_op[ALU_ADD] | alu_op[ALU_SUB]) &
                    (alu_src1[31] == b_in[31]) & (sum[31] != alu_src1[31]);

  assign alu_result =
      ({32{alu_op[ALU_ADD] | alu_op[ALU_SUB]}} & sum[31:0])
    | ({32{alu_op[ALU_SLT]}}  & {31'b0, slt_res})
    | ({32{alu_op[ALU_SLTU]}} & {31'b0, sltu_res})
    | ({32{alu_op[ALU_AND]}}  & (alu_src1 & alu_src2))
    | ({32{alu_op[ALU_NOR]}}  & ~(alu_src1 | alu_src2))
    | ({32{alu_op[ALU_OR]}}   & (alu_src1 | alu_src2))
    | ({32{alu_op[ALU_XOR]}}  & (alu_src1 ^ alu_src2))
    | ({32{alu_op[ALU_SLL]}}  & (alu_src2 << alu_src1[4:0]))
    | ({32{alu_op[ALU_SRL]}}  & (alu_src2 >> alu_src1[4:0]))
    | ({32{alu_op[ALU_SRA]}}  & sra_res)
    | ({32{alu_op[ALU_LUI]}}  & {alu_src2[15:0], 16'b0});

endmodule

// File: rtl/div_unit.sv
// 32-step restoring divider on operand magnitudes with signed fix-up.
// Divide by zero yields quotient all-ones and remainder = dividend.
module div_unit
  import mycpu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        abort,
  input  logic        ack,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic [1:0]  state
);

  localparam logic [1:0] S_IDLE = DIV_IDLE;
  localparam logic [1:0] S_BUSY = DIV_BUSY;
  localparam logic [1:0] S_DONE = DIV_DONE;

  logic [1:0]  state_q;
  logic [4:0]  step;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dsr_q;
  logic [31:0] dvd_q;
  logic        q_neg;
  logic        r_neg;
  logic        div_zero;
  logic [31:0] abs_dvd;
  logic [31:0] abs_dsr;
  logic [32:0] shifted;
  logic [32:0] trial;

  assign abs_dvd = (is_signed && dividend[31]) ? (~dividend + 32'd1) : dividend;
  assign abs_dsr = (is_signed && divisor[31])  ? (~divisor + 32'd1)  : divisor;

  // quo_q doubles as the dividend shift register feeding the partial remainder
  assign shifted = {rem_q, quo_q[31]};
  assign trial   = shifted - {1'b0, dsr_q};

  // divider FSM: abort and reset both return to IDLE immediately
  always_ff @(posedge clk) begin
    if (!resetn || abort) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_q <= S_BUSY;
        S_BUSY:  if (step == 5'(DIV_STEPS - 1)) state_q <= S_DONE;
        S_DONE:  if (ack) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // operand latch on start, one restoring step per BUSY cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      step     <= 5'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dsr_q    <= 32'd0;
      dvd_q    <= 32'd0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
    end else if (state_q == S_IDLE && start && !abort) begin
      step     <= 5'd0;
      rem_q    <= 32'd0;
      quo_q    <= abs_dvd;
      dsr_q    <= abs_dsr;
      dvd_q    <= dividend;
      q_neg    <= is_signed && (dividend[31] ^ divisor[31]);
      r_neg    <= is_signed && dividend[31];
      div_zero <= (divisor == 32'd0);
    end else if (state_q == S_BUSY) begin
      step <= step + 5'd1;
      if (!trial[32]) begin
        rem_q <= trial[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= shifted[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
    end
  end

  assign done      = (state_q == S_DONE);
  assign quotient  = div_zero ? 32'hFFFF_FFFF : (q_neg ? (~quo_q + 32'd1) : quo_q);
  assign remainder = div_zero ? dvd_q : (r_neg ? (~rem_q + 32'd1) : rem_q);
  assign state     = state_q;

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: registers decoded operands, runs the ALU, single-cycle
// multiply and iterative divide, owns HI/LO and flags arithmetic overflow.
module exe_stage
  import mycpu_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  exe_stage_if.slave      bus,
  output logic [1:0]      div_state
);

  logic        es_valid;
  logic [11:0] alu_op_q;
  logic [31:0] src1_q;
  logic [31:0] src2_q;
  logic [3:0]  md_op_q;
  logic [3:0]  hilo_op_q;
  logic        ov_en_q;
  logic [4:0]  dest_q;
  logic [31:0] pc_q;
  logic [31:0] hi;
  logic [31:0] lo;

  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        is_div;
  logic        ready_go;
  logic        leave;
  logic        ex;
  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;

  assign is_div   = md_op_q[MD_DIV] | md_op_q[MD_DIVU];
  assign ready_go = !is_div || div_done;
  assign leave    = bus.es_to_ms_valid && bus.ms_allowin;
  assign ex       = es_valid && ov_en_q && alu_overflow;

  assign bus.es_allowin     = !es_valid || (ready_go && bus.ms_allowin);
  assign bus.es_to_ms_valid = es_valid && ready_go;
  assign bus.es_ex          = ex;
  assign bus.es_dest        = dest_q;
  assign bus.es_pc          = pc_q;
  assign bus.es_result      = hilo_op_q[HILO_MFHI] ? hi :
                              hilo_op_q[HILO_MFLO] ? lo : alu_result;

  // stage occupancy; flush wins over a same-cycle capture
  always_ff @(posedge clk) begin
    if (!resetn) begin
      es_valid <= 1'b0;
    end else if (flush) begin
      es_valid <= 1'b0;
    end else if (bus.es_allowin) begin
      es_valid <= bus.ds_to_es_valid;
    end
  end

  // operand capture when decode hands over an instruction
  always_ff @(posedge clk) begin
    if (!resetn) begin
      alu_op_q  <= 12'd0;
      src1_q    <= 32'd0;
      src2_q    <= 32'd0;
      md_op_q   <= 4'd0;
      hilo_op_q <= 4'd0;
      ov_en_q   <= 1'b0;
      dest_q    <= 5'd0;
      pc_q      <= 32'd0;
    end else if (bus.ds_to_es_valid && bus.es_allowin && !flush) begin
      alu_op_q  <= bus.ds_alu_op;
      src1_q    <= bus.ds_src1;
      src2_q    <= bus.ds_src2;
      md_op_q   <= bus.ds_md_op;
      hilo_op_q <= bus.ds_hilo_op;
      ov_en_q   <= bus.ds_ov_en;
      dest_q    <= bus.ds_dest;
      pc_q      <= bus.ds_pc;
    end
  end

  alu u_alu (
    .alu_op     (alu_op_q),
    .alu_src1   (src1_q),
    .alu_src2   (src2_q),
    .alu_result (alu_result),
    .overflow   (alu_overflow)
  );

  // one shared multiplier: sign-extend for mult, zero-extend for multu
  assign mul_a   = {{32{md_op_q[MD_MULT] & src1_q[31]}}, src1_q};
  assign mul_b   = {{32{md_op_q[MD_MULT] & src2_q[31]}}, src2_q};
  assign product = mul_a * mul_b;

  div_unit u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (es_valid && is_div),
    .is_signed (md_op_q[MD_DIV]),
    .dividend  (src1_q),
    .divisor   (src2_q),
    .abort     (flush),
    .ack       (leave),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem),
    .state     (div_state)
  );

  // HI/LO update at the leave edge only, suppressed by an overflow trap
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (leave && !ex) begin
      if (md_op_q[MD_MULT] || md_op_q[MD_MULTU]) begin
        hi <= product[63:32];
        lo <= product[31:0];
      end else if (is_div) begin
        hi <= div_rem;
        lo <= div_quo;
      end else begin
        if (hilo_op_q[HILO_MTHI]) hi <= src1_q;
        if (hilo_op_q[HILO_MTLO]) lo <= src1_q;
      end
    end
  end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage MIPS pipeline. Sits between decode and memory, and registers decoded operands behind a valid/allowin handshake. Drives the existing combinational `alu` and owns the HI/LO registers. Performs single-cycle multiply and a 32-step iterative divide that stalls the stage, and flags arithmetic-overflow exceptions downstream.

## Interface
- No parameters; datapath fixed at 32 bits, register index 5 bits.
- Clocking: one clock; reset is synchronous and active-low.
- `clk`  in  1  pipeline clock.
- `resetn`  in  1  synchronous, active-low reset.
- `ds_to_es_valid`  in  1  decode presents an instruction.
- `es_allowin`  out  1  stage can accept this cycle.
- `ds_alu_op`  in  12  one-hot ALU op, bit order add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui.
- `ds_src1`, `ds_src2`  in  32  operands (shift amount in src1[4:0]).
- `ds_md_op`  in  4  one-hot {divu,div,multu,mult}; all zero = none.
- `ds_hilo_op`  in  4  one-hot {mtlo,mthi,mflo,mfhi}.
- `ds_ov_en`  in  1  overflow traps (add/addi/sub).
- `ds_dest`  in  5  destination register, 0 = none.
- `ds_pc`  in  32  instruction PC.
- `flush`  in  1  kill in-flight instruction.
- `ms_allowin`  in  1  memory stage can accept.
- `es_to_ms_valid`  out  1  result valid toward memory.
- `es_result`  out  32  ALU result, or HI/LO for mfhi/mflo.
- `es_dest`  out  5  registered dest.
- `es_pc`  out  32  registered PC.
- `es_ex`  out  1  overflow exception for this instruction.

## Operation
- `es_valid` register: on reset 0.
  - When `flush`, 0 next cycle; flush beats a simultaneous capture.
  - Else when `es_allowin`, loads `ds_to_es_valid`; fields captured only when `ds_to_es_valid && es_allowin`.
- Handshake signals:
  - `es_allowin = !es_valid || (es_ready_go && ms_allowin)`.
  - `es_to_ms_valid = es_valid && es_ready_go`.
  - `es_ready_go = !(div|divu) || div_state==DONE`.
- Leave event: `es_to_ms_valid && ms_allowin`.
- ALU: captured alu_op/src1/src2 feed `alu`; `es_ex = es_valid && ov_en && overflow`.
- Result select: mfhi→HI, mflo→LO, else `alu_result`.
- HI/LO register writes (reset 0) occur only at the leave event, and never when `es_ex`:
  - mult/multu: 64-bit signed/unsigned product, {HI,LO}.
  - div/divu: HI=remainder, LO=quotient.
  - mthi: HI=src1; mtlo: LO=src1.
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE→BUSY when `es_valid` and div/divu; latch magnitudes (signed op: abs of each operand) and clear step counter.
  - BUSY: one restoring step per cycle; counter 0..31; BUSY→DONE after step 31.
  - DONE→IDLE at the leave event.
  - `flush` or reset forces IDLE from any state.
- Signed fix-up: quotient negated when operand signs differ; remainder takes dividend's sign.
- Divide by zero, both div and divu: LO=0xFFFFFFFF, HI=src1, no exception.

## Timing
- ALU, mult, mfhi/mflo, mthi/mtlo instructions occupy the stage 1 cycle when `ms_allowin`=1.
- Div occupancy:
  - C0 = first cycle `es_valid`=1.
  - BUSY during C1–C32.
  - DONE and `es_ready_go`=1 in C33.
  - Minimum occupancy 34 cycles.
- Backpressure (`ms_allowin`=0): all outputs and DONE held stable, no HI/LO write.
- HI/LO forwarding: written at the leave edge, so an mfhi immediately behind a mult/div reads the new value.
- Reset values: `es_to_ms_valid`=0, `es_allowin`=1, `es_ex`=0, HI=LO=0, div_state=IDLE. `es_result`/`es_dest`/`es_pc` reset to 0.
- Reset or flush mid-divide: FSM IDLE next cycle, HI/LO unchanged, partial results discarded.

## Structure
- Shared package `mycpu_pkg` holds:
  - ALU op bit-index constants (12);
  - MD_OP and HILO_OP bit indices;
  - divider state enum;
  - DIV_STEPS=32.
- Sub-module `div_unit`: iterative divider plus FSM.
  - Inputs: start/signed/operands/abort.
  - Outputs: done/quotient/remainder.
- `alu` instantiated unchanged.

## Test plan
- Overflow: add 0x7FFFFFFF+0x00000001, ov_en=1 → es_ex=1, result 0x80000000. Same with ov_en=0 → es_ex=0.
- Multiply:
  - mult −3×5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - multu 0xFFFFFFFF×2 → HI=1, LO=0xFFFFFFFE.
  - Following mfhi → es_result=1.
- Signed divide: div −7/2 → es_allowin low C0–C32, es_to_ms_valid first in C33; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide by zero: divu 100/0 → LO=0xFFFFFFFF, HI=100, es_ex=0.
- Backpressure: ms_allowin low 5 cycles on an `or` → outputs constant, es_allowin=0; release → exactly one transfer.
- Flush mid-divide: flush at BUSY step 10 → es_valid=0 next cycle, HI/LO unchanged. Next divu 9/4 → LO=2, HI=1.
